segre_wb_arbiter: RTL

- Writeback stage downstream of the memory pipeline. It merges results from the ALU pipeline, the memory pipeline (MEM stage output) and the RVM pipeline onto the single register-file write port.
- MEM and RVM results are buffered in small FIFOs when they lose arbitration. Back-pressure is returned to those pipelines so the TL/MEM latch can hold.
- Outputs are registered and feed the register file and the history file (instr_id completion).

---
 rtl/segre_pkg.sv | 22 ++
 rtl/segre_wb_fifo.sv | 74 +++++++
 rtl/segre_wb_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/segre_pkg.sv
// Shared types for the segre writeback arbiter: source encoding and the
// default-width result entry buffered in the MEM/RVM FIFOs.
package segre_pkg;

  localparam int unsigned SEGRE_WORD_SIZE = 32;
  localparam int unsigned SEGRE_REG_SIZE  = 5;
  localparam int unsigned SEGRE_HF_PTR    = 4;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2,
    WB_RVM  = 2'd3
  } wb_src_e;

  typedef struct packed {
    logic [SEGRE_REG_SIZE-1:0]  waddr;
    logic [SEGRE_WORD_SIZE-1:0] data;
    logic [SEGRE_HF_PTR-1:0]    instr_id;
  } wb_entry_t;

endpackage

// File: rtl/segre_wb_fifo.sv
// Result FIFO for one stallable writeback source. Drops pushes when full with
// no pop and flags a sticky overflow. With SEGRE_WB_BYPASS_EN the contents are
// exposed oldest-first (index 0 = head) for the bypass search.
module segre_wb_fifo
  import segre_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   din,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
`ifdef SEGRE_WB_BYPASS_EN
  ,
  output entry_t                   entries [DEPTH],
  output logic [DEPTH-1:0]         valid
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  always_comb begin
    do_pop  = pop && (count != CW'(0));
    do_push = push && (!full || do_pop);
  end

  assign full = (count == CW'(DEPTH));
  assign head = mem[rd_ptr];

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= {PW{1'b0}};
      rd_ptr   <= {PW{1'b0}};
      count    <= {CW{1'b0}};
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

`ifdef SEGRE_WB_BYPASS_EN
  // Age-ordered view of the live entries.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      entries[i] = mem[rd_ptr + PW'(i)];
      valid[i]   = (CW'(i) < count);
    end
  end
`endif

endmodule

// File: rtl/segre_wb_arbiter.sv
// Writeback arbiter merging ALU, MEM and RVM results onto the register-file
// write port. Optional bypass lookup enabled by SEGRE_WB_BYPASS_EN.
module segre_wb_arbiter
  import segre_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned REG_SIZE    = 5,
  parameter int unsigned HF_PTR      = 4,
  parameter int unsigned MEM_Q_DEPTH = 4,
  parameter int unsigned RVM_Q_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 alu_rf_we_i,
  input  logic [REG_SIZE-1:0]  alu_rf_waddr_i,
  input  logic [WORD_SIZE-1:0] alu_data_i,
  input  logic [HF_PTR-1:0]    alu_instr_id_i,
  input  logic                 mem_rf_we_i,
  input  logic [REG_SIZE-1:0]  mem_rf_waddr_i,
  input  logic [WORD_SIZE-1:0] mem_data_i,
  input  logic [HF_PTR-1:0]    mem_instr_id_i,
  input  logic                 rvm_rf_we_i,
  input  logic [REG_SIZE-1:0]  rvm_rf_waddr_i,
  input  logic [WORD_SIZE-1:0] rvm_data_i,
  input  logic [HF_PTR-1:0]    rvm_instr_id_i,
  output logic                 mem_stall_o,
  output logic                 rvm_stall_o,
  output logic                 rf_we_o,
  output logic [REG_SIZE-1:0]  rf_waddr_o,
  output logic [WORD_SIZE-1:0] rf_data_o,
  output logic [HF_PTR-1:0]    instr_id_o,
  output logic [1:0]           wb_src_o,
  output logic                 overflow_o
`ifdef SEGRE_WB_BYPASS_EN
  ,
  input  logic [REG_SIZE-1:0]  byp_raddr_i,
  output logic                 byp_hit_o,
  output logic [WORD_SIZE-1:0] byp_data_o
`endif
);

  typedef struct packed {
    logic [REG_SIZE-1:0]  waddr;
    logic [WORD_SIZE-1:0] data;
    logic [HF_PTR-1:0]    instr_id;
  } entry_t;

  localparam int unsigned MCW = $clog2(MEM_Q_DEPTH) + 1;
  localparam int unsigned RCW = $clog2(RVM_Q_DEPTH) + 1;

  entry_t          alu_in, mem_in, rvm_in;
  entry_t          mem_head, rvm_head, mem_sel, rvm_sel, win;
  logic [MCW-1:0]  mem_count;
  logic [RCW-1:0]  rvm_count;
  logic            mem_full, rvm_full, mem_ovf, rvm_ovf;
  logic            mem_empty, rvm_empty, mem_cand, rvm_cand;
  logic            grant_mem, grant_rvm;
  logic            mem_push, mem_pop, rvm_push, rvm_pop;
  logic            rr_mem;
  wb_src_e         win_src;

  assign alu_in = '{waddr: alu_rf_waddr_i, data: alu_data_i, instr_id: alu_instr_id_i};
  assign mem_in = '{waddr: mem_rf_waddr_i, data: mem_data_i, instr_id: mem_instr_id_i};
  assign rvm_in = '{waddr: rvm_rf_waddr_i, data: rvm_data_i, instr_id: rvm_instr_id_i};

  // Candidate selection, priority/round-robin grant and FIFO push/pop.
  always_comb begin
    mem_empty = (mem_count == MCW'(0));
    rvm_empty = (rvm_count == RCW'(0));
    mem_cand  = !mem_empty || mem_rf_we_i;
    rvm_cand  = !rvm_empty || rvm_rf_we_i;
    mem_sel   = mem_empty ? mem_in : mem_head;
    rvm_sel   = rvm_empty ? rvm_in : rvm_head;
    grant_mem = !alu_rf_we_i && mem_cand && (!rvm_cand || rr_mem);
    grant_rvm = !alu_rf_we_i && rvm_cand && (!mem_cand || !rr_mem);
    if (alu_rf_we_i)    win_src = WB_ALU;
    else if (grant_mem) win_src = WB_MEM;
    else if (grant_rvm) win_src = WB_RVM;
    else                win_src = WB_NONE;
    case (win_src)
      WB_ALU:  win = alu_in;
      WB_MEM:  win = mem_sel;
      WB_RVM:  win = rvm_sel;
      default: win = '{waddr: {REG_SIZE{1'b0}}, data: {WORD_SIZE{1'b0}}, instr_id: {HF_PTR{1'b0}}};
    endcase
    // Cut-through only from an empty FIFO, so per-source order is preserved.
    mem_pop  = grant_mem && !mem_empty;
    rvm_pop  = grant_rvm && !rvm_empty;
    mem_push = mem_rf_we_i && !(grant_mem && mem_empty);
    rvm_push = rvm_rf_we_i && !(grant_rvm && rvm_empty);
  end

  // Round-robin pointer: favour the other source after each MEM/RVM grant.
  always_ff @(posedge clk_i) begin
    if (rsn_i)          rr_mem <= 1'b1;
    else if (grant_mem) rr_mem <= 1'b0;
    else if (grant_rvm) rr_mem <= 1'b1;
  end

  // Registered write port toward the register file and history file.
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= {REG_SIZE{1'b0}};
      rf_data_o  <= {WORD_SIZE{1'b0}};
      instr_id_o <= {HF_PTR{1'b0}};
      wb_src_o   <= WB_NONE;
    end else begin
      rf_we_o    <= (win_src != WB_NONE);
      rf_waddr_o <= win.waddr;
      rf_data_o  <= win.data;
      instr_id_o <= win.instr_id;
      wb_src_o   <= win_src;
    end
  end

  // Stalling one entry early leaves room for the result already in flight.
  assign mem_stall_o = mem_full || (mem_count >= MCW'(MEM_Q_DEPTH - 1));
  assign rvm_stall_o = rvm_full || (rvm_count >= RCW'(RVM_Q_DEPTH - 1));
  assign overflow_o  = mem_ovf || rvm_ovf;

`ifdef SEGRE_WB_BYPASS_EN
  entry_t                 mem_entries [MEM_Q_DEPTH];
  entry_t                 rvm_entries [RVM_Q_DEPTH];
  logic [MEM_Q_DEPTH-1:0] mem_valid;
  logic [RVM_Q_DEPTH-1:0] rvm_valid;
  logic                   m_hit;

  // Later (younger, higher-priority) matches override earlier ones.
  always_comb begin
    m_hit      = 1'b0;
    byp_hit_o  = 1'b0;
    byp_data_o = {WORD_SIZE{1'b0}};
    if (byp_raddr_i != {REG_SIZE{1'b0}}) begin
      byp_hit_o  = rf_we_o && (rf_waddr_o == byp_raddr_i);
      byp_data_o = byp_hit_o ? rf_data_o : {WORD_SIZE{1'b0}};
      for (int i = 0; i < int'(RVM_Q_DEPTH); i++) begin
        m_hit      = rvm_valid[i] && (rvm_entries[i].waddr == byp_raddr_i);
        byp_hit_o  = byp_hit_o || m_hit;
        byp_data_o = m_hit ? rvm_entries[i].data : byp_data_o;
      end
      for (int i = 0; i < int'(MEM_Q_DEPTH); i++) begin
        m_hit      = mem_valid[i] && (mem_entries[i].waddr == byp_raddr_i);
        byp_hit_o  = byp_hit_o || m_hit;
        byp_data_o = m_hit ? mem_entries[i].data : byp_data_o;
      end
    end else begin
      byp_hit_o  = 1'b0;
      byp_data_o = {WORD_SIZE{1'b0}};
    end
  end
`endif

  segre_wb_fifo #(.DEPTH(MEM_Q_DEPTH), .entry_t(entry_t)) u_mem_fifo (
    .clk      (clk_i),
    .rst      (rsn_i),
    .push     (mem_push),
    .pop      (mem_pop),
    .din      (mem_in),
    .head     (mem_head),
    .count    (mem_count),
    .full     (mem_full),
    .overflow (mem_ovf)
`ifdef SEGRE_WB_BYPASS_EN
    ,
    .entries  (mem_entries),
    .valid    (mem_valid)
`endif
  );

  segre_wb_fifo #(.DEPTH(RVM_Q_DEPTH), .entry_t(entry_t)) u_rvm_fifo (
    .clk      (clk_i),
    .rst      (rsn_i),
    .push     (rvm_push),
    .pop      (rvm_pop),
    .din      (rvm_in),
    .head     (rvm_head),
    .count    (rvm_count),
    .full     (rvm_full),
    .overflow (rvm_ovf)
`ifdef SEGRE_WB_BYPASS_EN
    ,
    .entries  (rvm_entries),
    .valid    (rvm_valid)
`endif
  );

endmodule
